// File: rtl/pwm_bank.sv
// pwm_bank: bank of NUM_CH PWM channels that share one prescaler and one
// CNT_W-bit period counter, configured through a simple byte-wide register
// port with a registered read path.
// Optional build macro: PWM_SHADOW_EN. When it is defined, each channel's
// duty is latched into a shadow register at the start of every period, so a
// duty write never changes the current period. When it is undefined, duty
// writes act on the running period straight away.
module pwm_bank #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [7:0]       ADDR_EN_OUT_LO = 8'h00;
    localparam logic [7:0]       ADDR_EN_OUT_HI = 8'h01;
    localparam logic [7:0]       ADDR_EN_PWM_LO = 8'h02;
    localparam logic [7:0]       ADDR_EN_PWM_HI = 8'h03;
    localparam logic [7:0]       ADDR_PRESCALE  = 8'h04;
    localparam logic [7:0]       ADDR_DUTY_BASE = 8'h10;
    localparam logic [4:0]       NUM_CH_L       = 5'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;

    // Configuration registers
    logic [NUM_CH-1:0] en_out_reg;
    logic [NUM_CH-1:0] en_pwm_reg;
    logic [NUM_CH-1:0] en_out_next;
    logic [NUM_CH-1:0] en_pwm_next;
    logic [7:0]        prescale_reg;
    logic [7:0]        duty_reg [NUM_CH];

    // Timebase
    logic [7:0]        pre_cnt_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              tick;
    logic              wrap;
    logic              prescale_wr;

    // Output path
    logic [CNT_W-1:0]  duty_eff [NUM_CH];
    logic [NUM_CH-1:0] raw_level;
    logic [NUM_CH-1:0] pwm_next;
    logic [NUM_CH-1:0] pwm_out_reg;
    logic              period_start_reg;
    logic [7:0]        rd_data_reg;
    logic [7:0]        rd_data_next;

    // Enable views padded to 16 bits so unimplemented channels read as 0
    logic [15:0]       en_out_pad;
    logic [15:0]       en_pwm_pad;

    assign prescale_wr = wr_en && (wr_addr == ADDR_PRESCALE);
    assign tick        = (pre_cnt_reg == prescale_reg);
    assign wrap        = tick && (cnt_reg == CNT_MAX);

    // Per-bit enable write merge: each channel bit lives in the low or high byte
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_en_next
        localparam logic [7:0] OUT_ADDR = (gi < 8) ? ADDR_EN_OUT_LO : ADDR_EN_OUT_HI;
        localparam logic [7:0] PWM_ADDR = (gi < 8) ? ADDR_EN_PWM_LO : ADDR_EN_PWM_HI;
        assign en_out_next[gi] = (wr_en && wr_addr == OUT_ADDR) ? wr_data[gi % 8] : en_out_reg[gi];
        assign en_pwm_next[gi] = (wr_en && wr_addr == PWM_ADDR) ? wr_data[gi % 8] : en_pwm_reg[gi];
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_en_pad
        if (gi < NUM_CH) begin : g_live
            assign en_out_pad[gi] = en_out_reg[gi];
            assign en_pwm_pad[gi] = en_pwm_reg[gi];
        end else begin : g_absent
            assign en_out_pad[gi] = 1'b0;
            assign en_pwm_pad[gi] = 1'b0;
        end
    end

    // Register file writes; unmapped addresses simply match nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_reg   <= '0;
            en_pwm_reg   <= '0;
            prescale_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_reg[i] <= '0;
            end
        end else begin
            en_out_reg <= en_out_next;
            en_pwm_reg <= en_pwm_next;
            if (prescale_wr) begin
                prescale_reg <= wr_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && wr_addr == ADDR_DUTY_BASE + 8'(i)) begin
                    duty_reg[i] <= wr_data;
                end
            end
        end
    end

    // Prescaler: a prescale write realigns the divider so the new rate starts cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg <= '0;
        end else if (prescale_wr || tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 8'd1;
        end
    end

    // Period counter and the wrap pulse that marks cnt_reg returning to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            if (tick) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            period_start_reg <= wrap;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] shadow_reg [NUM_CH];

    // Shadow duty is captured on the same edge the counter wraps, so it is
    // already live during the period_start cycle and stays fixed all period
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_reg[i] <= duty_reg[i][CNT_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_duty_eff
        assign duty_eff[gi] = shadow_reg[gi];
    end
`else
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_duty_eff
        assign duty_eff[gi] = duty_reg[gi][CNT_W-1:0];
    end
`endif

    // Raw compare, with full-scale duty pinned high so 100% has no dip at cnt=max
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_level
        assign raw_level[gi] = (duty_eff[gi] == CNT_MAX) ? 1'b1 : (cnt_reg < duty_eff[gi]);
        assign pwm_next[gi]  = en_out_reg[gi] & (~en_pwm_reg[gi] | raw_level[gi]);
    end

    // Registered channel pins
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out_reg <= '0;
        end else begin
            pwm_out_reg <= pwm_next;
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write reads old data
    always_comb begin
        rd_data_next = 8'h00;
        case (rd_addr)
            ADDR_EN_OUT_LO: rd_data_next = en_out_pad[7:0];
            ADDR_EN_OUT_HI: rd_data_next = en_out_pad[15:8];
            ADDR_EN_PWM_LO: rd_data_next = en_pwm_pad[7:0];
            ADDR_EN_PWM_HI: rd_data_next = en_pwm_pad[15:8];
            ADDR_PRESCALE:  rd_data_next = prescale_reg;
            default: begin
                if (rd_addr[7:4] == 4'h1 && {1'b0, rd_addr[3:0]} < NUM_CH_L) begin
                    rd_data_next = duty_reg[rd_addr[3:0]];
                end
            end
        endcase
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data      = rd_data_reg;
    assign pwm_out      = pwm_out_reg;
    assign period_start = period_start_reg;

endmodule
